// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types, default sizes and helpers for the instruction
//               memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int IMEM_N         = 32;
    localparam int IMEM_AW        = 6;
    localparam int IMEM_DEPTH     = 1 << IMEM_AW;
    localparam int CNT_W          = IMEM_AW + 1;
    localparam int BYTES_PER_WORD = IMEM_N / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of an index over n items; never zero, so 1-byte words stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Load-control, byte-stream and read-port bundle of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int N  = IMEM_N,
    parameter int AW = IMEM_AW
) ();

    logic          start;
    logic [AW:0]   len;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [AW:0]   wcount;
    logic [AW-1:0] addr;
    logic [N-1:0]  q;

    modport master (
        output start, len, in_valid, in_data, addr,
        input  in_ready, busy, done, wcount, q
    );

    modport slave (
        input  start, len, in_valid, in_data, addr,
        output in_ready, busy, done, wcount, q
    );

endinterface
`default_nettype wire

// File: rtl/imem_loader_ram.sv
`default_nettype none
// ============================================================================
// Module      : imem_ram
// Description : DEPTH x N register array, async clear, one synchronous write
//               port and one combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_ram
    import imem_loader_pkg::*;
#(
    parameter int N     = IMEM_N,
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [N-1:0]  wdata,
    input  wire logic [AW-1:0] addr,
    output      logic [N-1:0]  q
);

    logic [N-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Old contents are returned while the same address is being written.
    assign q = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Assembles a little-endian byte stream into N-bit words and
//               writes them sequentially into a writable instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int N     = IMEM_N,
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  wire logic clk,
    input  wire logic reset,
    imem_loader_if.slave bus
);

    localparam int BYTES  = N / 8;
    localparam int BIDX_W = idx_width(BYTES);
    localparam int CW     = AW + 1;
    localparam int HOLD_W = (BYTES > 1) ? (N - 8) : 8;

    localparam logic [BIDX_W-1:0] C_LAST_BYTE = BIDX_W'(BYTES - 1);
    localparam logic [CW-1:0]     C_DEPTH     = CW'(DEPTH);
    localparam logic [CW-1:0]     C_ONE       = CW'(1);

    state_t              r_state;
    logic                r_in_ready;
    logic                r_busy;
    logic                r_done;
    logic [CW-1:0]       r_wcount;
    logic [CW-1:0]       r_len;
    logic [AW-1:0]       r_ptr;
    logic [BIDX_W-1:0]   r_bidx;
    logic [HOLD_W-1:0]   r_hold;

    logic                w_accept;
    logic                w_last;
    logic                w_we;
    logic [N-1:0]        w_wdata;
    logic [CW-1:0]       w_len_sat;
    logic [N-1:0]        w_q;

    assign w_len_sat = (bus.len > C_DEPTH) ? C_DEPTH : bus.len;
    assign w_accept  = bus.in_valid && r_in_ready;
    assign w_last    = (r_bidx == C_LAST_BYTE);
    assign w_we      = w_accept && w_last;

    // The final byte goes straight to the write port; earlier bytes are held.
    if (BYTES > 1) begin : g_multi_byte
        assign w_wdata = {bus.in_data, r_hold};
    end else begin : g_single_byte
        assign w_wdata = bus.in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wcount   <= '0;
            r_len      <= '0;
            r_ptr      <= '0;
            r_bidx     <= '0;
            r_hold     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_len    <= w_len_sat;
                        r_wcount <= '0;
                        r_ptr    <= '0;
                        r_bidx   <= '0;
                        r_busy   <= 1'b1;
                        if (w_len_sat == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= LOAD;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_ptr    <= r_ptr + 1'b1;
                            r_wcount <= r_wcount + C_ONE;
                            r_bidx   <= '0;
                            if ((r_wcount + C_ONE) == r_len) begin
                                r_state    <= DONE;
                                r_in_ready <= 1'b0;
                                r_done     <= 1'b1;
                            end
                        end else begin
                            r_hold[8*r_bidx +: 8] <= bus.in_data;
                            r_bidx                <= r_bidx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    imem_ram #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (w_we),
        .waddr (r_ptr),
        .wdata (w_wdata),
        .addr  (bus.addr),
        .q     (w_q)
    );

    assign bus.in_ready = r_in_ready;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.wcount   = r_wcount;
    assign bus.q        = w_q;

endmodule
`default_nettype wire
